// File: rtl/wormhole_port_scheduler.sv
// Round-robin wormhole scheduler for one output port, with packet lock and credit gating.
// Define SCHED_CREDIT_EN to enable downstream credit counting and gating.
module wormhole_port_scheduler #(
    parameter int NUM_IN       = 2,
    parameter int CREDIT_DEPTH = 4,
    localparam int CW          = $clog2(CREDIT_DEPTH + 1),
    localparam int OW          = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [NUM_IN-1:0] req,
    input  logic [NUM_IN-1:0] req_head,
    input  logic [NUM_IN-1:0] req_tail,
    input  logic              credit_ret,
    output logic [NUM_IN-1:0] grant,
    output logic              busy,
    output logic [OW-1:0]     owner,
    output logic [CW-1:0]     credit_cnt,
    output logic              err
);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t            r_state;
    state_t            w_nstate;
    logic [OW-1:0]     r_rr;
    logic [OW-1:0]     w_nrr;
    logic [OW-1:0]     r_owner;
    logic [OW-1:0]     w_nowner;
    logic [OW-1:0]     w_winner;
    logic [OW-1:0]     w_idx;
    logic [OW:0]       w_sum;
    logic [NUM_IN-1:0] w_elig;
    logic [NUM_IN-1:0] w_grant;
    logic              w_found;
    logic              w_credit_ok;
    logic              w_err_set;
    logic              w_any;
    logic              w_ovf;
    logic              r_err;

    function automatic logic [OW-1:0] f_next(input logic [OW-1:0] i);
        if (i == OW'(NUM_IN - 1)) return '0;
        return i + 1'b1;
    endfunction

    assign w_elig = req & req_head;
    assign w_any  = |w_grant;

    // First eligible head flit at or after rr pointer, wrapping
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_sum = {1'b0, r_rr} + (OW+1)'(k);
            if (w_sum >= (OW+1)'(NUM_IN))
                w_sum = w_sum - (OW+1)'(NUM_IN);
            w_idx = w_sum[OW-1:0];
            if (!w_found && w_elig[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

`ifdef SCHED_CREDIT_EN
    logic [CW-1:0] r_credit;
    logic [CW-1:0] w_ncredit;

    assign w_credit_ok = (r_credit != '0);
    assign credit_cnt  = r_credit;

    always_comb begin
        w_ncredit = r_credit;
        w_ovf     = 1'b0;
        case ({w_any, credit_ret})
            2'b10: w_ncredit = r_credit - 1'b1;
            2'b01: begin
                if (r_credit == CW'(CREDIT_DEPTH))
                    w_ovf = 1'b1;
                else
                    w_ncredit = r_credit + 1'b1;
            end
            default: w_ncredit = r_credit;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_credit <= CW'(CREDIT_DEPTH);
        else        r_credit <= w_ncredit;
    end
`else
    logic w_unused;

    assign w_credit_ok = 1'b1;
    assign w_ovf       = 1'b0;
    assign w_unused    = credit_ret;
    assign credit_cnt  = CW'(CREDIT_DEPTH);
`endif

    always_comb begin
        w_grant   = '0;
        w_nstate  = r_state;
        w_nrr     = r_rr;
        w_nowner  = r_owner;
        w_err_set = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (|(req & ~req_head))
                    w_err_set = 1'b1;
                if (w_found && w_credit_ok) begin
                    w_grant[w_winner] = 1'b1;
                    if (req_tail[w_winner]) begin
                        w_nrr = f_next(w_winner);
                    end else begin
                        w_nstate = S_LOCKED;
                        w_nowner = w_winner;
                    end
                end
            end
            S_LOCKED: begin
                if (req[r_owner] && w_credit_ok) begin
                    w_grant[r_owner] = 1'b1;
                    if (req_head[r_owner])
                        w_err_set = 1'b1;
                    if (req_tail[r_owner]) begin
                        w_nstate = S_IDLE;
                        w_nrr    = f_next(r_owner);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_owner <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_rr    <= w_nrr;
            r_owner <= w_nowner;
            r_err   <= r_err | w_err_set | w_ovf;
        end
    end

    assign grant = w_grant;
    assign busy  = (r_state == S_LOCKED);
    assign owner = r_owner;
    assign err   = r_err;

endmodule

// File: tb/tb_wormhole_port_scheduler.sv
// Directed bench for wormhole_port_scheduler (NUM_IN=2, CREDIT_DEPTH=4).
// Expected credit values follow SCHED_CREDIT_EN when the bench is built with it.
module tb_wormhole_port_scheduler;

`ifdef SCHED_CREDIT_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_b;
    logic [1:0] req;
    logic [1:0] req_head;
    logic [1:0] req_tail;
    logic       credit_ret;
    logic [1:0] grant;
    logic       busy;
    logic       owner;
    logic [2:0] credit_cnt;
    logic       err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    wormhole_port_scheduler #(
        .NUM_IN(2),
        .CREDIT_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_b(rst_b),
        .req(req),
        .req_head(req_head),
        .req_tail(req_tail),
        .credit_ret(credit_ret),
        .grant(grant),
        .busy(busy),
        .owner(owner),
        .credit_cnt(credit_cnt),
        .err(err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] h,
                         input logic [1:0] t, input logic cr);
        req        = r;
        req_head   = h;
        req_tail   = t;
        credit_ret = cr;
        #1;
    endtask

    task automatic do_reset();
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        rst_b = 1'b0;
        #2;
        rst_b = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        #3;
        n_total++;
        if (grant !== 2'b00) $display("FAIL reset_grant got=%b exp=00", grant);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy);
        else n_pass++;
        n_total++;
        if (owner !== 1'b0) $display("FAIL reset_owner got=%b exp=0", owner);
        else n_pass++;
        n_total++;
        if (credit_cnt !== 3'd4) $display("FAIL reset_credit got=%0d exp=4", credit_cnt);
        else n_pass++;
        n_total++;
        if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err);
        else n_pass++;
        rst_b = 1'b1;
        step();
    endtask

    task automatic test_single();
        drive(2'b01, 2'b01, 2'b01, 1'b0);
        n_total++;
        if (grant !== 2'b01) $display("FAIL single_grant got=%b exp=01", grant);
        else n_pass++;
        step();
        n_total++;
        if (busy !== 1'b0) $display("FAIL single_busy got=%b exp=0", busy);
        else n_pass++;
        n_total++;
        if (credit_cnt !== (CE ? 3'd3 : 3'd4))
            $display("FAIL single_credit got=%0d exp=%0d", credit_cnt, CE ? 3 : 4);
        else n_pass++;
        // rr pointer now at 1: input 1 wins a tie
        drive(2'b11, 2'b11, 2'b11, 1'b1);
        n_total++;
        if (grant !== 2'b10) $display("FAIL single_rr_grant got=%b exp=10", grant);
        else n_pass++;
        step();
        n_total++;
        if (credit_cnt !== (CE ? 3'd3 : 3'd4))
            $display("FAIL single_ret_credit got=%0d exp=%0d", credit_cnt, CE ? 3 : 4);
        else n_pass++;
        drive(2'b00, 2'b00, 2'b00, 1'b1);
        step();
        n_total++;
        if (credit_cnt !== 3'd4) $display("FAIL single_refill got=%0d exp=4", credit_cnt);
        else n_pass++;
        n_total++;
        if (err !== 1'b0) $display("FAIL single_err got=%b exp=0", err);
        else n_pass++;
    endtask

    task automatic test_alternate();
        logic [8:0] exp_g;
        logic [8:0] exp_b;
        int pos [2];
        logic [1:0] h;
        logic [1:0] t;
        logic [1:0] eg;
        exp_g = 9'b000_111_000;
        exp_b = 9'b011_011_011;
        pos[0] = 0;
        pos[1] = 0;
        for (int k = 0; k < 9; k++) begin
            h = {pos[1] == 0, pos[0] == 0};
            t = {pos[1] == 2, pos[0] == 2};
            drive(2'b11, h, t, 1'b1);
            eg = exp_g[k] ? 2'b10 : 2'b01;
            n_total++;
            if (grant !== eg) $display("FAIL alt_grant[%0d] got=%b exp=%b", k, grant, eg);
            else n_pass++;
            pos[exp_g[k]] = (pos[exp_g[k]] + 1) % 3;
            step();
            n_total++;
            if (busy !== exp_b[k]) $display("FAIL alt_busy[%0d] got=%b exp=%b", k, busy, exp_b[k]);
            else n_pass++;
            n_total++;
            if (owner !== exp_g[k]) $display("FAIL alt_owner[%0d] got=%b exp=%b", k, owner, exp_g[k]);
            else n_pass++;
        end
        n_total++;
        if (credit_cnt !== 3'd4) $display("FAIL alt_credit got=%0d exp=4", credit_cnt);
        else n_pass++;
        n_total++;
        if (err !== 1'b0) $display("FAIL alt_err got=%b exp=0", err);
        else n_pass++;
    endtask

    task automatic test_stall();
        drive(2'b01, 2'b01, 2'b00, 1'b0);
        n_total++;
        if (grant !== 2'b01) $display("FAIL stall_head_grant got=%b exp=01", grant);
        else n_pass++;
        step();
        for (int k = 0; k < 3; k++) begin
            drive(2'b10, 2'b10, 2'b00, 1'b0);
            n_total++;
            if (grant !== 2'b00) $display("FAIL stall_grant[%0d] got=%b exp=00", k, grant);
            else n_pass++;
            step();
            n_total++;
            if (busy !== 1'b1) $display("FAIL stall_busy[%0d] got=%b exp=1", k, busy);
            else n_pass++;
        end
        drive(2'b01, 2'b00, 2'b01, 1'b0);
        n_total++;
        if (grant !== 2'b01) $display("FAIL stall_resume got=%b exp=01", grant);
        else n_pass++;
        step();
        n_total++;
        if (busy !== 1'b0) $display("FAIL stall_tail_busy got=%b exp=0", busy);
        else n_pass++;
        n_total++;
        if (credit_cnt !== (CE ? 3'd2 : 3'd4))
            $display("FAIL stall_credit got=%0d exp=%0d", credit_cnt, CE ? 2 : 4);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        drive(2'b01, 2'b01, 2'b01, 1'b1);
        n_total++;
        if (grant !== 2'b01) $display("FAIL same_grant got=%b exp=01", grant);
        else n_pass++;
        step();
        n_total++;
        if (credit_cnt !== (CE ? 3'd2 : 3'd4))
            $display("FAIL same_credit got=%0d exp=%0d", credit_cnt, CE ? 2 : 4);
        else n_pass++;
        drive(2'b00, 2'b00, 2'b00, 1'b1);
        step();
        step();
        n_total++;
        if (credit_cnt !== 3'd4) $display("FAIL same_refill got=%0d exp=4", credit_cnt);
        else n_pass++;
    endtask

    task automatic test_credit_gate();
`ifdef SCHED_CREDIT_EN
        drive(2'b01, 2'b01, 2'b00, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(2'b01, 2'b00, 2'b00, 1'b0);
            n_total++;
            if (grant !== 2'b01) $display("FAIL gate_body[%0d] got=%b exp=01", k, grant);
            else n_pass++;
            step();
        end
        n_total++;
        if (credit_cnt !== 3'd0) $display("FAIL gate_empty got=%0d exp=0", credit_cnt);
        else n_pass++;
        drive(2'b01, 2'b00, 2'b00, 1'b0);
        n_total++;
        if (grant !== 2'b00) $display("FAIL gate_block got=%b exp=00", grant);
        else n_pass++;
        step();
        drive(2'b01, 2'b00, 2'b00, 1'b1);
        n_total++;
        if (grant !== 2'b00) $display("FAIL gate_block_ret got=%b exp=00", grant);
        else n_pass++;
        step();
        n_total++;
        if (credit_cnt !== 3'd1) $display("FAIL gate_one got=%0d exp=1", credit_cnt);
        else n_pass++;
        drive(2'b01, 2'b00, 2'b00, 1'b0);
        n_total++;
        if (grant !== 2'b01) $display("FAIL gate_extra got=%b exp=01", grant);
        else n_pass++;
        step();
        n_total++;
        if (grant !== 2'b00) $display("FAIL gate_after_extra got=%b exp=00", grant);
        else n_pass++;
        step();
        n_total++;
        if (busy !== 1'b1) $display("FAIL gate_busy got=%b exp=1", busy);
        else n_pass++;
        drive(2'b00, 2'b00, 2'b00, 1'b1);
        for (int k = 0; k < 4; k++) step();
        drive(2'b01, 2'b00, 2'b01, 1'b0);
        n_total++;
        if (grant !== 2'b01) $display("FAIL gate_tail got=%b exp=01", grant);
        else n_pass++;
        step();
        n_total++;
        if (credit_cnt !== 3'd3) $display("FAIL gate_tail_credit got=%0d exp=3", credit_cnt);
        else n_pass++;
        drive(2'b00, 2'b00, 2'b00, 1'b1);
        step();
`else
        drive(2'b01, 2'b01, 2'b00, 1'b0);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(2'b01, 2'b00, 2'b00, 1'b1);
            n_total++;
            if (grant !== 2'b01) $display("FAIL gate_body[%0d] got=%b exp=01", k, grant);
            else n_pass++;
            step();
        end
        drive(2'b01, 2'b00, 2'b01, 1'b1);
        n_total++;
        if (grant !== 2'b01) $display("FAIL gate_tail got=%b exp=01", grant);
        else n_pass++;
        step();
`endif
        n_total++;
        if (busy !== 1'b0) $display("FAIL gate_end_busy got=%b exp=0", busy);
        else n_pass++;
        n_total++;
        if (credit_cnt !== 3'd4) $display("FAIL gate_end_credit got=%0d exp=4", credit_cnt);
        else n_pass++;
        n_total++;
        if (err !== 1'b0) $display("FAIL gate_err got=%b exp=0", err);
        else n_pass++;
    endtask

    task automatic test_overflow();
        drive(2'b00, 2'b00, 2'b00, 1'b1);
        step();
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        n_total++;
        if (credit_cnt !== 3'd4) $display("FAIL ovf_credit got=%0d exp=4", credit_cnt);
        else n_pass++;
        n_total++;
        if (err !== CE) $display("FAIL ovf_err got=%b exp=%b", err, CE);
        else n_pass++;
    endtask

    task automatic test_idle_nonhead();
        do_reset();
        drive(2'b10, 2'b00, 2'b00, 1'b0);
        n_total++;
        if (grant !== 2'b00) $display("FAIL nonhead_grant got=%b exp=00", grant);
        else n_pass++;
        step();
        n_total++;
        if (err !== 1'b1) $display("FAIL nonhead_err got=%b exp=1", err);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL nonhead_busy got=%b exp=0", busy);
        else n_pass++;
    endtask

    task automatic test_head_in_body();
        do_reset();
        drive(2'b10, 2'b10, 2'b00, 1'b0);
        n_total++;
        if (grant !== 2'b10) $display("FAIL hib_head got=%b exp=10", grant);
        else n_pass++;
        step();
        drive(2'b11, 2'b11, 2'b00, 1'b0);
        n_total++;
        if (grant !== 2'b10) $display("FAIL hib_body got=%b exp=10", grant);
        else n_pass++;
        step();
        n_total++;
        if (err !== 1'b1) $display("FAIL hib_err got=%b exp=1", err);
        else n_pass++;
        n_total++;
        if (busy !== 1'b1) $display("FAIL hib_busy got=%b exp=1", busy);
        else n_pass++;
        n_total++;
        if (owner !== 1'b1) $display("FAIL hib_owner got=%b exp=1", owner);
        else n_pass++;
        n_total++;
        if (credit_cnt !== (CE ? 3'd2 : 3'd4))
            $display("FAIL hib_credit got=%0d exp=%0d", credit_cnt, CE ? 2 : 4);
        else n_pass++;
    endtask

    task automatic test_midpacket_reset();
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        #2;
        rst_b = 1'b0;
        #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL arst_busy got=%b exp=0", busy);
        else n_pass++;
        n_total++;
        if (owner !== 1'b0) $display("FAIL arst_owner got=%b exp=0", owner);
        else n_pass++;
        n_total++;
        if (credit_cnt !== 3'd4) $display("FAIL arst_credit got=%0d exp=4", credit_cnt);
        else n_pass++;
        n_total++;
        if (err !== 1'b0) $display("FAIL arst_err got=%b exp=0", err);
        else n_pass++;
        #2;
        rst_b = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_stall();
        test_same_cycle();
        test_credit_gate();
        test_overflow();
        test_idle_nonhead();
        test_head_in_body();
        test_midpacket_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wormhole_port_scheduler.md
# wormhole_port_scheduler

Per-output-port wormhole scheduler for the router fabric. It arbitrates round-robin among NUM_IN input FIFOs competing for one output port and locks the port to the winning input from head flit to tail flit. It also gates every grant on downstream buffer credits. One instance sits between the input FIFO heads and each output port mux; its one-hot grant drives both the FIFO read strobe and the output mux select.

## Interface
- NUM_IN, 2, number of requesting input ports (≥2)
- CREDIT_DEPTH, 4, downstream buffer depth in flits (≥1)
- CW, $clog2(CREDIT_DEPTH+1), credit counter width (derived)

- clk  in  1  rising-edge clock; sole clock domain
- rst_b  in  1  asynchronous, active-low reset
- req  in  NUM_IN  input i has a flit at FIFO head destined to this port
- req_head  in  NUM_IN  flit at head of input i is a head flit
- req_tail  in  NUM_IN  flit at head of input i is a tail flit (head+tail = single-flit packet)
- credit_ret  in  1  downstream freed one flit slot this cycle
- grant  out  NUM_IN  one-hot (or zero) grant; combinational, same cycle as req
- busy  out  1  port locked to a packet (state LOCKED)
- owner  out  $clog2(NUM_IN)  index of the current or last lock owner
- credit_cnt  out  CW  available downstream credits
- err  out  1  sticky error flag

## Operation
- State machine: IDLE, LOCKED. Reset → IDLE.
- credit_ok = (credit_cnt != 0). No grant is issued while credit_ok = 0.
- IDLE: eligible[i] = req[i] & req_head[i]. The winner is the first eligible index searching from rr_ptr upward, with wrap. If credit_ok, grant[winner] = 1.
  - Granted flit with req_tail = 1: stay IDLE; rr_ptr ← winner+1 mod NUM_IN.
  - Otherwise: → LOCKED, owner ← winner.
- LOCKED: grant[owner] = req[owner] & credit_ok. All other inputs see 0, even if they hold head flits.
  - A granted flit with req_tail = 1 → IDLE; rr_ptr ← owner+1 mod NUM_IN.
  - owner stalling (req low) holds the lock indefinitely.
- Non-head flit requesting in IDLE is ineligible, never granted. Sets err.
- Head flit from owner while LOCKED (req_head=1, not first flit) is still granted as body. Sets err.
- Credit counter: −1 on any grant, +1 on credit_ret.
  - Both in the same cycle: unchanged.
  - credit_ret while credit_cnt = CREDIT_DEPTH and no grant: ignored (saturates). Sets err.
- err is cleared only by reset.

## Timing
- Reset values: state IDLE, rr_ptr 0, owner 0, busy 0, credit_cnt CREDIT_DEPTH, err 0, grant 0.
- grant is combinational from req/req_head/state/credit_cnt: zero-cycle latency. The FIFO pops on the same edge.
- state, owner, rr_ptr, credit_cnt and err update on the rising clk edge following the grant or credit event.
- busy rises the cycle after a multi-flit head grant. It falls the cycle after the tail grant.
- Back-to-back packets: a new head may be granted the cycle after the tail grant, with no bubble.
- Reset asserted mid-packet: immediate return to reset values. The upstream/downstream is reset together; no packet recovery.

## Configuration
- SCHED_CREDIT_EN defined: credit counting, credit gating and credit overflow err are active as above.
- Not defined:
  - credit_ok is constant 1 and credit_ret is ignored.
  - credit_cnt is tied to CREDIT_DEPTH.
  - err reflects only protocol errors.

## Test plan
- Reset, then req=01, req_head=01, req_tail=01, single-flit → grant=01 same cycle; busy stays 0; rr_ptr=1; credit_cnt 4→3.
- Inputs 0 and 1 both present head flits every cycle, 3-flit packets, credit_ret every cycle → grants alternate by packet: 0,0,0,1,1,1,0,0,0. busy=1 between head and tail.
- Lock on input 0 after its head; input 0 drops req for 3 cycles while input 1 holds a head → grant=00 for those cycles; busy stays 1; input 0 resumes and is granted.
- SCHED_CREDIT_EN, CREDIT_DEPTH=4, no credit_ret, 6-flit packet → 4 grants, then grant=00 with credit_cnt=0. One credit_ret → exactly one more grant next cycle.
- credit_ret and grant in the same cycle at credit_cnt=2 → credit_cnt stays 2. credit_ret at credit_cnt=4 with no grant → count stays 4; err=1.
- req=10 with req_head=00 in IDLE → grant=00; err=1. Assert rst_b=0 mid-packet → busy=0, credit_cnt=4, err=0 asynchronously.
